lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the ALU: consumes the ALU result as the effective address and rs2 as store data.
- Drives a single-outstanding valid/grant/rvalid data-memory bus.
- Holds the core with `stall` until the access completes.
- Returns aligned, sign- or zero-extended load data for register writeback.
- Flags misaligned or illegal accesses and bus timeouts.

---
 rtl/lsu_mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
// Load/store unit that sits right after the ALU. The ALU result is the
// effective address and rs2 is the store data. It runs one access at a time
// over a valid/grant/rvalid data-memory bus and holds the core with stall
// until that access finishes. Load data comes back aligned and sign- or
// zero-extended for register writeback. Misaligned or illegal requests and
// bus timeouts are flagged with one-cycle pulses.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   req_valid      memory instruction present this cycle
//   req_we         1 = store, 0 = load
//   req_funct3     000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr       effective address
//   req_wdata      store data
//   stall          core must hold PC and request while high
//   rdata          extended load data (held between responses)
//   rdata_valid    one-cycle pulse when a load completes
//   align_err      one-cycle pulse: misaligned address or illegal funct3
//   bus_err        one-cycle pulse: access aborted by timeout
//   mem_req        bus request, held until mem_gnt
//   mem_we         write strobe
//   mem_addr       word address
//   mem_be         byte enables
//   mem_wdata      lane-replicated store data
//   mem_gnt        request accepted this cycle
//   mem_rvalid     read data / write acknowledge
//   mem_rdata      read word
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        align_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    // The abort fires in the last allowed cycle, so the pulse lands
    // TIMEOUT_CYCLES cycles after entering REQ or WAIT.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [9:0]  r_count;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_align_err;
    logic        r_bus_err;

    logic        w_legal;
    logic        w_accept;
    logic        w_fault;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // Legality, byte-enable and store-lane replication for the incoming request
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~req_addr[0];
            3'b010:         w_legal = (req_addr[1:0] == 2'b00);
            default:        w_legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && req_valid && w_legal;
    assign w_fault   = (r_state == S_IDLE) && req_valid && !w_legal;
    assign w_timeout = (r_count == TO_LAST);

    // Load data extraction from the latched offset and size
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {24'b0, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {16'b0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs. Grant wins over a same-cycle
    // timeout, and a grant cycle never doubles as a response cycle.
    // stall is masked by rst so every output is low while reset is held.
    always_comb begin
        w_next      = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall  = ~rst;
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                mem_we  = r_we;
                stall   = 1'b1;
                if (mem_gnt)        w_next = S_WAIT;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid)     w_next = S_RESP;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_RESP: begin
                rdata_valid = ~r_we;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timeout counter restarts on every state change and counts while
    // waiting on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 10'd0;
        end else if (r_state != w_next) begin
            r_count <= 10'd0;
        end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_count <= r_count + 10'd1;
        end
    end

    // Request capture so the bus sees stable values for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_off       <= req_addr[1:0];
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
        end
    end

    // Load result register and one-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata     <= 32'd0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= w_fault;
            r_bus_err   <= ((r_state == S_REQ)  && !mem_gnt    && w_timeout) ||
                           ((r_state == S_WAIT) && !mem_rvalid && w_timeout);
            if (r_state == S_WAIT && mem_rvalid && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

    assign rdata     = r_rdata;
    assign align_err = r_align_err;
    assign bus_err   = r_bus_err;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage: directed scenarios followed by randomized
// accesses, all checked against a behavioural model of sizes, lanes and
// extension rules.
module tb_lsu_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        align_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] expRdata;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .align_err(align_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Behavioural model
    function automatic bit refLegal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int refSize(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] refBe(input logic [2:0] f3, input logic [1:0] off);
        int mask;
        mask = (1 << refSize(f3)) - 1;
        return 4'(mask << off);
    endfunction

    function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [63:0] v;
        logic [63:0] mask;
        int          sz;
        sz   = refSize(f3);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = 64'd0;
        for (int i = 0; i < 4 / sz; i++) v = v | (({32'd0, wd} & mask) << (8 * sz * i));
        return v[31:0];
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] word,
                                            input logic [1:0] off);
        logic [63:0] s;
        longint      v;
        int          sz;
        sz = refSize(f3);
        if (sz == 4) return word;
        s = {32'd0, word} >> (8 * off);
        v = longint'(s & ((64'd1 << (8 * sz)) - 64'd1));
        if (!f3[2] && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
        return 32'(v);
    endfunction

    task automatic nextCycle;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // One complete access starting in an IDLE cycle; ends in the IDLE cycle after RESP
    task automatic doAccess(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                            input int gntDelay, input int rvDelay);
        bit legal;
        legal = refLegal(f3, a);
        applyStimulus(1'b1, we, f3, a, wd);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        checkOutput({tag, ".stall_req"}, 32'(stall), 32'(legal));
        checkOutput({tag, ".noreq_idle"}, 32'(mem_req), 32'd0);
        nextCycle;
        if (!legal) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            #1;
            checkOutput({tag, ".align_err"}, 32'(align_err), 32'd1);
            checkOutput({tag, ".align_noreq"}, 32'(mem_req), 32'd0);
            checkOutput({tag, ".align_stall"}, 32'(stall), 32'd0);
            checkOutput({tag, ".align_buserr"}, 32'(bus_err), 32'd0);
            nextCycle;
            #1;
            checkOutput({tag, ".align_pulse_end"}, 32'(align_err), 32'd0);
            checkOutput({tag, ".align_still_idle"}, 32'(mem_req), 32'd0);
            return;
        end
        for (int k = 0; k <= gntDelay; k++) begin
            mem_gnt    = (k == gntDelay);
            mem_rvalid = (k == gntDelay) && ($urandom_range(0, 1) == 1);
            mem_rdata  = ~word;
            #1;
            checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd1);
            checkOutput({tag, ".stall_req_state"}, 32'(stall), 32'd1);
            checkOutput({tag, ".mem_we"}, 32'(mem_we), 32'(we));
            checkOutput({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
            checkOutput({tag, ".mem_be"}, 32'(mem_be), 32'(refBe(f3, a[1:0])));
            if (we) checkOutput({tag, ".mem_wdata"}, mem_wdata, refWdata(f3, wd));
            nextCycle;
        end
        mem_gnt = 1'b0;
        for (int k = 0; k <= rvDelay; k++) begin
            mem_rvalid = (k == rvDelay);
            mem_rdata  = (k == rvDelay) ? word : $urandom;
            #1;
            checkOutput({tag, ".wait_noreq"}, 32'(mem_req), 32'd0);
            checkOutput({tag, ".wait_stall"}, 32'(stall), 32'd1);
            checkOutput({tag, ".wait_norv"}, 32'(rdata_valid), 32'd0);
            nextCycle;
        end
        mem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        if (!we) expRdata = refLoad(f3, word, a[1:0]);
        #1;
        checkOutput({tag, ".resp_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(!we));
        checkOutput({tag, ".rdata"}, rdata, expRdata);
        checkOutput({tag, ".resp_buserr"}, 32'(bus_err), 32'd0);
        nextCycle;
        #1;
        checkOutput({tag, ".rv_pulse_end"}, 32'(rdata_valid), 32'd0);
        checkOutput({tag, ".rdata_hold"}, rdata, expRdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic        we;
        logic [31:0] a;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        expRdata = 32'd0;
        #1;
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset.rdata", rdata, 32'd0);
        checkOutput("reset.rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("reset.mem_addr", mem_addr, 32'd0);
        nextCycle;
        nextCycle;
        rst = 1'b0;
        nextCycle;

        doAccess("lb", 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0);
        checkOutput("lb.const", rdata, 32'hFFFF_FF80);
        doAccess("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0, 0);
        checkOutput("lhu.const", rdata, 32'h0000_BEEF);
        doAccess("lh", 1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 0, 0);
        checkOutput("lh.const", rdata, 32'hFFFF_BEEF);
        doAccess("sb", 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h1234_5678, 4, 1);
        checkOutput("sb.rdata_kept", rdata, 32'hFFFF_BEEF);
        doAccess("lw_mis", 1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'd0, 0, 0);
        doAccess("f3_011", 1'b0, 3'b011, 32'h0000_4000, 32'd0, 32'd0, 0, 0);

        // Timeout while waiting for rvalid
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0);
        nextCycle;
        mem_gnt = 1'b1;
        #1;
        checkOutput("to_wait.mem_req", 32'(mem_req), 32'd1);
        nextCycle;
        mem_gnt = 1'b0;
        for (int k = 0; k < TO; k++) begin
            #1;
            checkOutput("to_wait.stall", 32'(stall), 32'd1);
            checkOutput("to_wait.early_buserr", 32'(bus_err), 32'd0);
            nextCycle;
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("to_wait.bus_err", 32'(bus_err), 32'd1);
        checkOutput("to_wait.stall_low", 32'(stall), 32'd0);
        checkOutput("to_wait.mem_req", 32'(mem_req), 32'd0);
        nextCycle;
        #1;
        checkOutput("to_wait.pulse_end", 32'(bus_err), 32'd0);
        checkOutput("to_wait.late_rv", 32'(rdata_valid), 32'd0);
        mem_rvalid = 1'b0;
        nextCycle;
        #1;
        checkOutput("to_wait.late_rv2", 32'(rdata_valid), 32'd0);
        checkOutput("to_wait.rdata", rdata, expRdata);

        // Timeout while waiting for grant
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_5100, 32'h1111_2222);
        nextCycle;
        for (int k = 0; k < TO; k++) begin
            #1;
            checkOutput("to_req.mem_req", 32'(mem_req), 32'd1);
            checkOutput("to_req.early_buserr", 32'(bus_err), 32'd0);
            nextCycle;
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        checkOutput("to_req.bus_err", 32'(bus_err), 32'd1);
        checkOutput("to_req.mem_req_low", 32'(mem_req), 32'd0);
        nextCycle;
        mem_gnt = 1'b1;
        #1;
        checkOutput("to_req.pulse_end", 32'(bus_err), 32'd0);
        checkOutput("to_req.idle", 32'(mem_req), 32'd0);
        nextCycle;
        mem_gnt = 1'b0;

        // Reset in the middle of WAIT
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0);
        nextCycle;
        mem_gnt = 1'b1;
        nextCycle;
        mem_gnt = 1'b0;
        #1;
        checkOutput("rst_mid.stall_before", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        expRdata = 32'd0;
        checkOutput("rst_mid.mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mid.stall", 32'(stall), 32'd0);
        checkOutput("rst_mid.rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("rst_mid.bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_mid.align_err", 32'(align_err), 32'd0);
        checkOutput("rst_mid.rdata", rdata, 32'd0);
        nextCycle;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        checkOutput("rst_mid.late_rv", 32'(rdata_valid), 32'd0);
        nextCycle;
        mem_rvalid = 1'b0;
        #1;
        checkOutput("rst_mid.late_rv2", 32'(rdata_valid), 32'd0);
        checkOutput("rst_mid.rdata_clear", rdata, 32'd0);
        doAccess("lw_after_rst", 1'b0, 3'b010, 32'h0000_6004, 32'd0, 32'h0123_4567, 1, 2);

        // Randomized back-to-back accesses
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b011;
                    default: f3 = 3'b110;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (refSize(f3) == 2) a[0] = 1'b0;
                if (refSize(f3) == 4) a[1:0] = 2'b00;
            end
            doAccess($sformatf("rnd%0d", i), we, f3, a, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
